bus_arbiter2: RTL and testbench
===============================

# bus_arbiter2

Two-master arbiter for the shared single-slave bus (wr/rd/address/length/wdata/rdata/ready/rddatavalid). It sits between two bus-master FSMs and the slave port. It grants the bus round-robin and holds the grant for a complete burst. Release happens when the last write beat is accepted or the last read beat is returned, so bursts from different masters never interleave.

## Interface
- ADDR_W, 4, address width
- LEN_W, 4, burst length field width
- DATA_W, 32, data width
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- io_mN_wr / io_mN_rd  in  1 each  (N = 0,1) master N write / read request
- io_mN_address  in  ADDR_W  master N start address
- io_mN_length  in  LEN_W  master N beat count
- io_mN_wdata  in  DATA_W  master N write data
- io_mN_ready  out  1  slave ready, routed to master N only while granted
- io_mN_rddatavalid  out  1  read beat valid, routed only while master N owns a read burst
- io_mN_rdata  out  DATA_W  slave rdata, broadcast to both masters
- io_mN_grant  out  1  master N owns the bus
- io_s_wr, io_s_rd  out  1  to slave
- io_s_address  out  ADDR_W  to slave
- io_s_length  out  LEN_W  to slave
- io_s_wdata  out  DATA_W  to slave
- io_s_ready  in  1  slave accepts command / write beat
- io_s_rddatavalid  in  1  slave read beat valid
- io_s_rdata  in  DATA_W  slave read data

## Operation
- States:
  - IDLE: no owner, all io_s_* = 0.
  - CMD: owner's wr/rd/address/length/wdata drive io_s_*.
  - WRITE: owner's wdata and wr drive the slave, address/length = 0.
  - READ: io_s_* = 0; waiting for read beats.
- Arbitration in IDLE:
  - reqN = io_mN_wr | io_mN_rd.
  - If only one master requests, grant it.
  - If both request, grant the master other than the last granted master.
  - The last-grant pointer updates when the grant is issued.
- beats = length, with length 0 treated as 1.
- If wr and rd are both asserted, wr wins and rd is ignored for that command.
- CMD transitions:
  - io_s_ready=1 with wr and beats=1 → IDLE.
  - io_s_ready=1 with wr and beats>1 → WRITE, cnt = beats-1. The command cycle carries the first beat.
  - io_s_ready=1 with rd → READ, cnt = beats.
  - Owner drops both wr and rd before acceptance → IDLE, grant released, pointer kept.
- WRITE: each cycle with io_s_ready=1 accepts one beat and decrements cnt; cnt reaching 0 → IDLE.
- READ:
  - Each io_s_rddatavalid=1 decrements cnt; cnt reaching 0 → IDLE.
  - Owner's wr/rd are ignored; io_mN_ready = 0.
- Routing:
  - io_mN_ready = io_s_ready only in CMD/WRITE with owner N; otherwise 0.
  - io_mN_rddatavalid = io_s_rddatavalid only in READ with owner N; otherwise 0.
  - io_s_rddatavalid in IDLE/CMD/WRITE is dropped.

## Timing
- Reset (synchronous): state=IDLE, owner none, last-grant pointer = 1 (master 0 wins first tie), cnt=0.
  - All outputs 0 the cycle after reset, except io_mN_rdata, which mirrors io_s_rdata.
- Reset mid-burst aborts the burst at the next edge. No completion is signalled.
- Arbitration latency: request seen in IDLE at edge k → CMD with grant at edge k+1.
  - Earliest command acceptance is the cycle after the request.
- Grant, ready, rddatavalid and io_s_* are combinational from state/owner registers and slave inputs. No extra pipeline stage.
- Release takes effect at the edge that accepts the last beat; the next cycle is IDLE.
  - Minimum gap between back-to-back bursts: one IDLE cycle.
- A new request arriving during a burst waits. Owner N's own new request during its burst is not queued; it re-arbitrates in IDLE.
- cnt is LEN_W bits wide and never wraps. Decrement happens only when cnt > 0.

## Structure
- Package bus_pkg:
  - ADDR_W, LEN_W, DATA_W constants.
  - arb_state_t enum {IDLE, CMD, WRITE, READ}.
  - beats(length) helper for the 0→1 rule.
- Sub-module rr_arb2:
  - Inputs: req[1:0], pointer register, load enable.
  - Output: one-hot grant.
  - Reused by a future N-master arbiter.
- Top: FSM, beat counter, owner register, output muxes.

## Test plan
- Reset then single read: m0 rd=1, address=4, length=1. Slave ready=1 on the CMD cycle, rddatavalid one cycle later. Required: m0_grant high 2 cycles after request (CMD+READ), m0_rddatavalid pulses once, then IDLE.
- Write burst: m1 wr=1, length=3, wdata 0xA,0xB,0xC. Slave ready held 1. Required: io_s_wdata shows 3 beats over 3 cycles, m1_ready high 3 cycles, release after the third beat.
- Contention: m0 and m1 both rd, length=1, from reset. Required order: m0 first, then m1. After m0 re-requests, m1 ↔ m0 alternate, one IDLE cycle between bursts.
- Read burst with gaps: m0 rd, length=3, rddatavalid pattern 1,0,1,0,1. Required: grant held until the third valid, m1 request held off throughout, m1 never sees rddatavalid.
- Withdraw and corner cases:
  - m1 rd with ready=0 for 2 cycles, then m1 drops rd. Required: back to IDLE, no slave transaction, pointer unchanged.
  - length=0 read completes after 1 beat.
  - wr&rd together performs a write.
- Reset mid-read burst (length=3, after 1 beat). Required: IDLE and all grants 0 the next cycle; a stray rddatavalid afterwards is not routed.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   ADDR_W / LEN_W / DATA_W : bus field widths
//   arb_state_t             : arbiter FSM states
//   beats()                 : burst beat count, a length of 0 means one beat
package bus_pkg;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WRITE,
    READ
  } arb_state_t;

  function automatic logic [LEN_W-1:0] beats(input logic [LEN_W-1:0] length);
    return (length == '0) ? LEN_W'(1) : length;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selector with its own last-grant pointer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_req[1:0]   : request per requester
//   i_load       : commit the current grant into the last-grant pointer
//   o_grant[1:0] : one-hot grant (all zero when nobody requests)
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_load,
  output logic [1:0] o_grant
);

  logic r_last;  // index of the requester granted most recently

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;  // favour the one not served last
      default: o_grant = 2'b00;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= 1'b1;  // master 0 wins the first tie
    end else if (i_load && (o_grant != 2'b00)) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master arbiter in front of a single bus slave. Grants round-robin and
// holds the grant for a whole burst, so bursts never interleave.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   io_mN_wr/rd/address/length/wdata (in)  : master N command and write data
//   io_mN_ready (out)        : slave ready, only while N owns CMD/WRITE
//   io_mN_rddatavalid (out)  : read beat valid, only while N owns a read burst
//   io_mN_rdata (out)        : slave read data, broadcast
//   io_mN_grant (out)        : master N owns the bus
//   io_s_* (out)             : command/write path to the slave
//   io_s_ready/rddatavalid/rdata (in) : slave responses
module bus_arbiter2
  import bus_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_m0_wr,
  input  logic              io_m0_rd,
  input  logic [ADDR_W-1:0] io_m0_address,
  input  logic [LEN_W-1:0]  io_m0_length,
  input  logic [DATA_W-1:0] io_m0_wdata,
  output logic              io_m0_ready,
  output logic              io_m0_rddatavalid,
  output logic [DATA_W-1:0] io_m0_rdata,
  output logic              io_m0_grant,
  input  logic              io_m1_wr,
  input  logic              io_m1_rd,
  input  logic [ADDR_W-1:0] io_m1_address,
  input  logic [LEN_W-1:0]  io_m1_length,
  input  logic [DATA_W-1:0] io_m1_wdata,
  output logic              io_m1_ready,
  output logic              io_m1_rddatavalid,
  output logic [DATA_W-1:0] io_m1_rdata,
  output logic              io_m1_grant,
  output logic              io_s_wr,
  output logic              io_s_rd,
  output logic [ADDR_W-1:0] io_s_address,
  output logic [LEN_W-1:0]  io_s_length,
  output logic [DATA_W-1:0] io_s_wdata,
  input  logic              io_s_ready,
  input  logic              io_s_rddatavalid,
  input  logic [DATA_W-1:0] io_s_rdata
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic [LEN_W-1:0]  r_cnt,   w_cnt_nxt;

  logic [1:0]        w_req;
  logic [1:0]        w_arb_grant;
  logic              w_own_wr;
  logic              w_own_rd;
  logic [ADDR_W-1:0] w_own_address;
  logic [LEN_W-1:0]  w_own_length;
  logic [DATA_W-1:0] w_own_wdata;
  logic [LEN_W-1:0]  w_beats;
  logic              w_busy;
  logic              w_wr_phase;

  assign w_req = {io_m1_wr | io_m1_rd, io_m0_wr | io_m0_rd};

  rr_arb2 u_rr_arb2 (
    .clock   (clock),
    .reset   (reset),
    .i_req   (w_req),
    .i_load  (r_state == IDLE),
    .o_grant (w_arb_grant)
  );

  // Owner's command fields; write wins when both wr and rd are raised.
  assign w_own_wr      = r_owner ? io_m1_wr      : io_m0_wr;
  assign w_own_rd      = (r_owner ? io_m1_rd     : io_m0_rd) & ~w_own_wr;
  assign w_own_address = r_owner ? io_m1_address : io_m0_address;
  assign w_own_length  = r_owner ? io_m1_length  : io_m0_length;
  assign w_own_wdata   = r_owner ? io_m1_wdata   : io_m0_wdata;
  assign w_beats       = beats(w_own_length);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_arb_grant != 2'b00) begin
          w_state_nxt = CMD;
          w_owner_nxt = w_arb_grant[1];
        end
      end
      CMD: begin
        if (!w_own_wr && !w_own_rd) begin
          w_state_nxt = IDLE;  // owner withdrew before acceptance
        end else if (io_s_ready) begin
          if (w_own_wr) begin
            // The command cycle already carries the first write beat.
            if (w_beats == LEN_W'(1)) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WRITE;
              w_cnt_nxt   = w_beats - LEN_W'(1);
            end
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = w_beats;
          end
        end
      end
      WRITE: begin
        if (io_s_ready && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) w_state_nxt = IDLE;
        end
      end
      READ: begin
        if (io_s_rddatavalid && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  assign w_busy     = (r_state != IDLE);
  assign w_wr_phase = (r_state == CMD) || (r_state == WRITE);

  always_comb begin
    io_s_wr      = 1'b0;
    io_s_rd      = 1'b0;
    io_s_address = '0;
    io_s_length  = '0;
    io_s_wdata   = '0;
    case (r_state)
      CMD: begin
        io_s_wr      = w_own_wr;
        io_s_rd      = w_own_rd;
        io_s_address = w_own_address;
        io_s_length  = w_own_length;
        io_s_wdata   = w_own_wdata;
      end
      WRITE: begin
        io_s_wr    = w_own_wr;
        io_s_wdata = w_own_wdata;
      end
      default: ;
    endcase
  end

  assign io_m0_grant       = w_busy && !r_owner;
  assign io_m1_grant       = w_busy &&  r_owner;
  assign io_m0_ready       = w_wr_phase && !r_owner && io_s_ready;
  assign io_m1_ready       = w_wr_phase &&  r_owner && io_s_ready;
  // Read beats outside READ have no owner and are dropped.
  assign io_m0_rddatavalid = (r_state == READ) && !r_owner && io_s_rddatavalid;
  assign io_m1_rddatavalid = (r_state == READ) &&  r_owner && io_s_rddatavalid;
  assign io_m0_rdata       = io_s_rdata;
  assign io_m1_rdata       = io_s_rdata;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed testbench for bus_arbiter2 with hand-computed expectations.
module tb_bus_arbiter2;
  import bus_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_m0_wr, io_m0_rd, io_m1_wr, io_m1_rd;
  logic [ADDR_W-1:0] io_m0_address, io_m1_address;
  logic [LEN_W-1:0]  io_m0_length, io_m1_length;
  logic [DATA_W-1:0] io_m0_wdata, io_m1_wdata;
  logic              io_m0_ready, io_m1_ready;
  logic              io_m0_rddatavalid, io_m1_rddatavalid;
  logic [DATA_W-1:0] io_m0_rdata, io_m1_rdata;
  logic              io_m0_grant, io_m1_grant;
  logic              io_s_wr, io_s_rd;
  logic [ADDR_W-1:0] io_s_address;
  logic [LEN_W-1:0]  io_s_length;
  logic [DATA_W-1:0] io_s_wdata;
  logic              io_s_ready, io_s_rddatavalid;
  logic [DATA_W-1:0] io_s_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  bus_arbiter2 dut (
    .clock             (clock),
    .reset             (reset),
    .io_m0_wr          (io_m0_wr),
    .io_m0_rd          (io_m0_rd),
    .io_m0_address     (io_m0_address),
    .io_m0_length      (io_m0_length),
    .io_m0_wdata       (io_m0_wdata),
    .io_m0_ready       (io_m0_ready),
    .io_m0_rddatavalid (io_m0_rddatavalid),
    .io_m0_rdata       (io_m0_rdata),
    .io_m0_grant       (io_m0_grant),
    .io_m1_wr          (io_m1_wr),
    .io_m1_rd          (io_m1_rd),
    .io_m1_address     (io_m1_address),
    .io_m1_length      (io_m1_length),
    .io_m1_wdata       (io_m1_wdata),
    .io_m1_ready       (io_m1_ready),
    .io_m1_rddatavalid (io_m1_rddatavalid),
    .io_m1_rdata       (io_m1_rdata),
    .io_m1_grant       (io_m1_grant),
    .io_s_wr           (io_s_wr),
    .io_s_rd           (io_s_rd),
    .io_s_address      (io_s_address),
    .io_s_length       (io_s_length),
    .io_s_wdata        (io_s_wdata),
    .io_s_ready        (io_s_ready),
    .io_s_rddatavalid  (io_s_rddatavalid),
    .io_s_rdata        (io_s_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 ns after the edge; checks run 2 ns later, mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    io_m0_wr = 0; io_m0_rd = 0; io_m0_address = '0; io_m0_length = '0; io_m0_wdata = '0;
    io_m1_wr = 0; io_m1_rd = 0; io_m1_address = '0; io_m1_length = '0; io_m1_wdata = '0;
    io_s_ready = 0; io_s_rddatavalid = 0; io_s_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] cont_exp [0:7];  // {grant0, grant1, rdv0, rdv1} per cycle
    logic [4:0] gap_pat;

    cont_exp[0] = 4'b0000; cont_exp[1] = 4'b1000; cont_exp[2] = 4'b1010; cont_exp[3] = 4'b0000;
    cont_exp[4] = 4'b0100; cont_exp[5] = 4'b0101; cont_exp[6] = 4'b0000; cont_exp[7] = 4'b1000;
    gap_pat = 5'b10101;

    // ---- reset state ----
    reset = 1; idle_all();
    tick(); tick();
    reset = 0;
    io_s_ready = 1; io_s_rddatavalid = 1; io_s_rdata = 32'h1234_5678;
    settle();
    check("rst_grant0", 32'(io_m0_grant), 32'd0);
    check("rst_grant1", 32'(io_m1_grant), 32'd0);
    check("rst_s_rd", 32'(io_s_rd), 32'd0);
    check("rst_s_wr", 32'(io_s_wr), 32'd0);
    check("rst_m0_ready", 32'(io_m0_ready), 32'd0);
    check("rst_m0_rdv", 32'(io_m0_rddatavalid), 32'd0);
    check("rst_rdata_m0", io_m0_rdata, 32'h1234_5678);
    check("rst_rdata_m1", io_m1_rdata, 32'h1234_5678);
    tick();

    // ---- single read from m0 ----
    idle_all();
    io_m0_rd = 1; io_m0_address = 4'd4; io_m0_length = 4'd1;
    settle();
    check("rd1_idle_grant0", 32'(io_m0_grant), 32'd0);
    tick();
    io_s_ready = 1;
    settle();
    check("rd1_cmd_grant0", 32'(io_m0_grant), 32'd1);
    check("rd1_cmd_s_rd", 32'(io_s_rd), 32'd1);
    check("rd1_cmd_addr", 32'(io_s_address), 32'd4);
    check("rd1_cmd_len", 32'(io_s_length), 32'd1);
    check("rd1_cmd_m0_ready", 32'(io_m0_ready), 32'd1);
    check("rd1_cmd_m1_ready", 32'(io_m1_ready), 32'd0);
    tick();
    io_m0_rd = 0; io_s_ready = 0; io_s_rddatavalid = 1;
    settle();
    check("rd1_read_grant0", 32'(io_m0_grant), 32'd1);
    check("rd1_read_s_rd", 32'(io_s_rd), 32'd0);
    check("rd1_read_m0_rdv", 32'(io_m0_rddatavalid), 32'd1);
    check("rd1_read_m1_rdv", 32'(io_m1_rddatavalid), 32'd0);
    tick();
    io_s_rddatavalid = 0;
    settle();
    check("rd1_done_grant0", 32'(io_m0_grant), 32'd0);
    tick();

    // ---- write burst from m1, 3 beats ----
    idle_all();
    io_m1_wr = 1; io_m1_length = 4'd3; io_m1_address = 4'd9; io_m1_wdata = 32'hA; io_s_ready = 1;
    settle();
    check("wr_idle_m1_ready", 32'(io_m1_ready), 32'd0);
    check("wr_idle_s_wr", 32'(io_s_wr), 32'd0);
    tick();
    settle();
    check("wr_cmd_grant1", 32'(io_m1_grant), 32'd1);
    check("wr_cmd_s_wr", 32'(io_s_wr), 32'd1);
    check("wr_cmd_wdata", io_s_wdata, 32'hA);
    check("wr_cmd_len", 32'(io_s_length), 32'd3);
    check("wr_cmd_m1_ready", 32'(io_m1_ready), 32'd1);
    tick();
    io_m1_wdata = 32'hB;
    settle();
    check("wr_b2_wdata", io_s_wdata, 32'hB);
    check("wr_b2_s_wr", 32'(io_s_wr), 32'd1);
    check("wr_b2_addr", 32'(io_s_address), 32'd0);
    check("wr_b2_len", 32'(io_s_length), 32'd0);
    check("wr_b2_m1_ready", 32'(io_m1_ready), 32'd1);
    tick();
    io_m1_wdata = 32'hC;
    settle();
    check("wr_b3_wdata", io_s_wdata, 32'hC);
    check("wr_b3_m1_ready", 32'(io_m1_ready), 32'd1);
    tick();
    io_m1_wr = 0; io_s_ready = 0;
    settle();
    check("wr_done_grant1", 32'(io_m1_grant), 32'd0);
    check("wr_done_s_wr", 32'(io_s_wr), 32'd0);

    // ---- contention from reset: m0, m1, m0 ----
    reset = 1; idle_all();
    tick();
    reset = 0;
    io_m0_rd = 1; io_m0_length = 4'd1; io_m1_rd = 1; io_m1_length = 4'd1;
    io_s_ready = 1; io_s_rddatavalid = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("cont_c%0d_grant0", i), 32'(io_m0_grant), 32'(cont_exp[i][3]));
      check($sformatf("cont_c%0d_grant1", i), 32'(io_m1_grant), 32'(cont_exp[i][2]));
      check($sformatf("cont_c%0d_rdv0", i), 32'(io_m0_rddatavalid), 32'(cont_exp[i][1]));
      check($sformatf("cont_c%0d_rdv1", i), 32'(io_m1_rddatavalid), 32'(cont_exp[i][0]));
      tick();
    end
    io_m0_rd = 0; io_m1_rd = 0;
    settle();
    check("cont_c8_grant0", 32'(io_m0_grant), 32'd1);
    tick();
    settle();
    check("cont_end_grant0", 32'(io_m0_grant), 32'd0);
    check("cont_end_grant1", 32'(io_m1_grant), 32'd0);
    tick();

    // ---- m0 read burst with gaps, m1 held off ----
    idle_all();
    io_m0_rd = 1; io_m0_length = 4'd3; io_s_ready = 1;
    settle();
    check("gap_idle_grant0", 32'(io_m0_grant), 32'd0);
    tick();
    io_m1_rd = 1; io_m1_length = 4'd1;
    settle();
    check("gap_cmd_grant0", 32'(io_m0_grant), 32'd1);
    check("gap_cmd_grant1", 32'(io_m1_grant), 32'd0);
    check("gap_cmd_m1_ready", 32'(io_m1_ready), 32'd0);
    tick();
    io_m0_rd = 0;
    for (int i = 0; i < 5; i++) begin
      io_s_rddatavalid = gap_pat[i];
      settle();
      check($sformatf("gap_r%0d_grant0", i), 32'(io_m0_grant), 32'd1);
      check($sformatf("gap_r%0d_grant1", i), 32'(io_m1_grant), 32'd0);
      check($sformatf("gap_r%0d_rdv0", i), 32'(io_m0_rddatavalid), 32'(gap_pat[i]));
      check($sformatf("gap_r%0d_rdv1", i), 32'(io_m1_rddatavalid), 32'd0);
      check($sformatf("gap_r%0d_m0_ready", i), 32'(io_m0_ready), 32'd0);
      tick();
    end
    io_s_rddatavalid = 0;
    settle();
    check("gap_done_grant0", 32'(io_m0_grant), 32'd0);
    check("gap_done_grant1", 32'(io_m1_grant), 32'd0);
    tick();
    settle();
    check("gap_m1_cmd_grant1", 32'(io_m1_grant), 32'd1);
    tick();
    io_m1_rd = 0; io_s_rddatavalid = 1;
    settle();
    check("gap_m1_read_rdv1", 32'(io_m1_rddatavalid), 32'd1);
    tick();
    io_s_rddatavalid = 0;
    tick();

    // ---- m1 withdraws before acceptance ----
    idle_all();
    io_m1_rd = 1; io_m1_length = 4'd2; io_m1_address = 4'd7;
    tick();
    settle();
    check("wd_cmd1_grant1", 32'(io_m1_grant), 32'd1);
    check("wd_cmd1_m1_ready", 32'(io_m1_ready), 32'd0);
    check("wd_cmd1_s_rd", 32'(io_s_rd), 32'd1);
    tick();
    settle();
    check("wd_cmd2_grant1", 32'(io_m1_grant), 32'd1);
    tick();
    io_m1_rd = 0;
    settle();
    check("wd_drop_s_rd", 32'(io_s_rd), 32'd0);
    check("wd_drop_s_wr", 32'(io_s_wr), 32'd0);
    tick();
    // Pointer still names m1, so m0 wins this tie; both ask for length 0.
    io_m0_rd = 1; io_m0_length = 4'd0; io_m1_rd = 1; io_m1_length = 4'd0; io_s_ready = 1;
    settle();
    check("wd_idle_grant1", 32'(io_m1_grant), 32'd0);
    check("wd_idle_s_rd", 32'(io_s_rd), 32'd0);
    tick();
    settle();
    check("len0_cmd_grant0", 32'(io_m0_grant), 32'd1);
    check("len0_cmd_grant1", 32'(io_m1_grant), 32'd0);
    check("len0_cmd_len", 32'(io_s_length), 32'd0);
    tick();
    io_m0_rd = 0; io_s_rddatavalid = 1;
    settle();
    check("len0_read_rdv0", 32'(io_m0_rddatavalid), 32'd1);
    check("len0_read_grant0", 32'(io_m0_grant), 32'd1);
    tick();
    io_m1_rd = 0; io_s_rddatavalid = 0;
    settle();
    check("len0_done_grant0", 32'(io_m0_grant), 32'd0);
    check("len0_done_grant1", 32'(io_m1_grant), 32'd0);
    tick();

    // ---- wr and rd together perform a write ----
    idle_all();
    io_m0_wr = 1; io_m0_rd = 1; io_m0_length = 4'd1; io_m0_wdata = 32'h55; io_s_ready = 1;
    tick();
    settle();
    check("wrrd_cmd_s_wr", 32'(io_s_wr), 32'd1);
    check("wrrd_cmd_s_rd", 32'(io_s_rd), 32'd0);
    check("wrrd_cmd_wdata", io_s_wdata, 32'h55);
    tick();
    io_m0_wr = 0; io_m0_rd = 0; io_s_rddatavalid = 1;
    settle();
    check("wrrd_done_grant0", 32'(io_m0_grant), 32'd0);
    check("wrrd_done_rdv0", 32'(io_m0_rddatavalid), 32'd0);
    tick();

    // ---- reset in the middle of a read burst ----
    idle_all();
    io_m0_rd = 1; io_m0_length = 4'd3; io_s_ready = 1;
    tick();
    tick();
    io_m0_rd = 0; io_s_rddatavalid = 1;
    settle();
    check("rstmid_beat1_rdv0", 32'(io_m0_rddatavalid), 32'd1);
    tick();
    io_s_rddatavalid = 0; reset = 1;
    settle();
    check("rstmid_pre_grant0", 32'(io_m0_grant), 32'd1);
    tick();
    reset = 0; io_s_rddatavalid = 1;
    settle();
    check("rstmid_grant0", 32'(io_m0_grant), 32'd0);
    check("rstmid_grant1", 32'(io_m1_grant), 32'd0);
    check("rstmid_rdv0", 32'(io_m0_rddatavalid), 32'd0);
    check("rstmid_rdv1", 32'(io_m1_rddatavalid), 32'd0);
    check("rstmid_s_rd", 32'(io_s_rd), 32'd0);
    tick();
    io_s_rddatavalid = 0;
    settle();
    check("rstmid_after_grant0", 32'(io_m0_grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
